// File: rtl/melody_sequencer.sv
// Melody sequencer: steps through a fixed 16-entry ROM and drives a one-hot note select
// with beat timing and an inter-note gap. Define MELODY_LOOP_EN for endless looping playback.
module melody_sequencer #(
  parameter int BEAT_CYCLES = 250000,
  parameter int GAP_CYCLES  = 10000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       stop,
  output logic [7:0] note_sel,
  output logic       busy,
  output logic       done,
  output logic [3:0] idx
);

  localparam int CW = $clog2(4 * BEAT_CYCLES);
  localparam logic [CW-1:0] GAP_LOAD = CW'(GAP_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE,
    NOTE,
    GAP
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [3:0]    idx_d;
  logic [7:0]    note_d;
  logic          done_d;
  logic [5:0]    nxt_entry;

  // ROM entry format is {duration[1:0], note_code[3:0]}
  function automatic logic [5:0] rom_entry(input logic [3:0] i);
    case (i)
      4'd0, 4'd1:   rom_entry = {2'd0, 4'd1};
      4'd2, 4'd3:   rom_entry = {2'd0, 4'd5};
      4'd4, 4'd5:   rom_entry = {2'd0, 4'd6};
      4'd6:         rom_entry = {2'd1, 4'd5};
      4'd7, 4'd8:   rom_entry = {2'd0, 4'd4};
      4'd9, 4'd10:  rom_entry = {2'd0, 4'd3};
      4'd11, 4'd12: rom_entry = {2'd0, 4'd2};
      4'd13:        rom_entry = {2'd1, 4'd1};
      default:      rom_entry = {2'd0, 4'd0};
    endcase
  endfunction

  function automatic logic [7:0] decode(input logic [3:0] code);
    decode = (code == 4'd0) ? 8'h00 : (8'h01 << (code - 4'd1));
  endfunction

  function automatic logic [CW-1:0] note_load(input logic [1:0] d);
    note_load = CW'((int'(d) + 1) * BEAT_CYCLES - GAP_CYCLES - 1);
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      idx      <= 4'd0;
      note_sel <= 8'h00;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      idx      <= idx_d;
      note_sel <= note_d;
      busy     <= (state_d != IDLE);
      done     <= done_d;
    end
  end

  // Outputs are computed for the next state so that they appear registered with no lag
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    idx_d     = idx;
    note_d    = note_sel;
    done_d    = 1'b0;
    nxt_entry = rom_entry(4'd0);
    if (stop) begin
      state_d = IDLE;
      cnt_d   = '0;
      idx_d   = 4'd0;
      note_d  = 8'h00;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            state_d = NOTE;
            idx_d   = 4'd0;
            cnt_d   = note_load(nxt_entry[5:4]);
            note_d  = decode(nxt_entry[3:0]);
          end
        end
        NOTE: begin
          if (cnt_q == '0) begin
            state_d = GAP;
            cnt_d   = GAP_LOAD;
            note_d  = 8'h00;
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end
        GAP: begin
          if (cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
          end else if (idx != 4'd15) begin
            nxt_entry = rom_entry(idx + 4'd1);
            state_d   = NOTE;
            idx_d     = idx + 4'd1;
            cnt_d     = note_load(nxt_entry[5:4]);
            note_d    = decode(nxt_entry[3:0]);
          end else begin
`ifdef MELODY_LOOP_EN
            state_d = NOTE;
            idx_d   = 4'd0;
            cnt_d   = note_load(nxt_entry[5:4]);
            note_d  = decode(nxt_entry[3:0]);
`else
            // The done cycle doubles as the single idle cycle before a restart
            state_d = IDLE;
            idx_d   = 4'd0;
            cnt_d   = '0;
            note_d  = 8'h00;
            done_d  = 1'b1;
`endif
          end
        end
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
          idx_d   = 4'd0;
          note_d  = 8'h00;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_melody_sequencer.sv
// Self-checking bench for melody_sequencer: vector table, hand sequences and a
// randomized run against a timeline model of the song.
module tb_melody_sequencer;

  localparam int BEAT = 10;
  localparam int GAP  = 2;
  localparam int SONG = 18 * BEAT;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       stop;
  logic [7:0] note_sel;
  logic       busy;
  logic       done;
  logic [3:0] idx;

  int checks = 0;
  int failures = 0;

  // Song as written on the score: note code (0 = rest) and length in beats
  int song_code[16]  = '{1, 1, 5, 5, 6, 6, 5, 4, 4, 3, 3, 2, 2, 1, 0, 0};
  int song_beats[16] = '{1, 1, 1, 1, 1, 1, 2, 1, 1, 1, 1, 1, 1, 2, 1, 1};

  bit m_play;
  int m_k;
  bit m_done;

  typedef struct {
    bit         start;
    bit         stop;
    logic [7:0] note;
    logic [3:0] idx;
    bit         busy;
    bit         done;
  } vec_t;

  vec_t vecs[9];

  melody_sequencer #(.BEAT_CYCLES(BEAT), .GAP_CYCLES(GAP)) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .stop(stop),
    .note_sel(note_sel),
    .busy(busy),
    .done(done),
    .idx(idx)
  );

  always #5 clk = ~clk;

  // Expected note and entry k cycles after the start edge, found by walking the score
  task automatic song_at(input int k, output logic [7:0] n, output logic [3:0] i);
    int t = k;
    n = 8'h00;
    i = 4'd0;
    for (int e = 0; e < 16; e++) begin
      int len = song_beats[e] * BEAT;
      if (t < len) begin
        i = 4'(e);
        if (t < len - GAP && song_code[e] != 0) n = 8'(1 << (song_code[e] - 1));
        return;
      end
      t -= len;
    end
  endtask

  task automatic model_edge(input bit s, input bit p);
    m_done = 1'b0;
    if (p) begin
      m_play = 1'b0;
    end else if (!m_play) begin
      if (s) begin
        m_play = 1'b1;
        m_k    = 0;
      end
    end else begin
      m_k++;
      if (m_k == SONG) begin
`ifdef MELODY_LOOP_EN
        m_k = 0;
`else
        m_play = 1'b0;
        m_done = 1'b1;
`endif
      end
    end
  endtask

  task automatic check1(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic checkOutput(input string name, input logic [7:0] en, input logic [3:0] ei,
                             input bit eb, input bit ed);
    check1({name, ".note_sel"}, note_sel, en);
    check1({name, ".idx"}, {4'd0, idx}, {4'd0, ei});
    check1({name, ".busy"}, {7'd0, busy}, {7'd0, eb});
    check1({name, ".done"}, {7'd0, done}, {7'd0, ed});
  endtask

  task automatic checkModel(input string name);
    logic [7:0] n;
    logic [3:0] i;
    if (m_play) song_at(m_k, n, i);
    else begin
      n = 8'h00;
      i = 4'd0;
    end
    checkOutput(name, n, i, m_play, m_done);
  endtask

  // Inputs change at the falling edge; outputs are sampled at the following falling edge
  task automatic applyStimulus(input bit s, input bit p);
    start = s;
    stop  = p;
    @(posedge clk);
    @(negedge clk);
    model_edge(s, p);
  endtask

  initial begin
    rst    = 1'b1;
    start  = 1'b0;
    stop   = 1'b0;
    m_play = 1'b0;
    m_k    = 0;
    m_done = 1'b0;
    vecs[0] = '{1, 1, 8'h00, 4'd0, 0, 0};
    vecs[1] = '{0, 0, 8'h00, 4'd0, 0, 0};
    vecs[2] = '{1, 0, 8'h01, 4'd0, 1, 0};
    vecs[3] = '{0, 0, 8'h01, 4'd0, 1, 0};
    vecs[4] = '{1, 0, 8'h01, 4'd0, 1, 0};
    vecs[5] = '{0, 1, 8'h00, 4'd0, 0, 0};
    vecs[6] = '{0, 0, 8'h00, 4'd0, 0, 0};
    vecs[7] = '{1, 0, 8'h01, 4'd0, 1, 0};
    vecs[8] = '{1, 1, 8'h00, 4'd0, 0, 0};

    repeat (2) @(negedge clk);
    checkOutput("reset", 8'h00, 4'd0, 0, 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    checkOutput("idle_after_reset", 8'h00, 4'd0, 0, 0);

    foreach (vecs[v]) begin
      applyStimulus(vecs[v].start, vecs[v].stop);
      checkOutput($sformatf("vec%0d", v), vecs[v].note, vecs[v].idx, vecs[v].busy, vecs[v].done);
    end
    applyStimulus(0, 0);

    // Single entry timing and full song against the model
    applyStimulus(1, 0);
    checkModel("song_c0");
    for (int c = 1; c < SONG; c++) begin
      applyStimulus(0, 0);
      checkModel($sformatf("song_c%0d", c));
    end
    applyStimulus(0, 0);
`ifdef MELODY_LOOP_EN
    checkOutput("loop_wrap", 8'h01, 4'd0, 1, 0);
    for (int c = 0; c < 400; c++) begin
      applyStimulus(0, 0);
      checkModel("loop_run");
    end
    applyStimulus(0, 1);
    checkOutput("loop_stop", 8'h00, 4'd0, 0, 0);
`else
    checkOutput("song_done", 8'h00, 4'd0, 0, 1);
    applyStimulus(0, 0);
    checkOutput("done_pulse_end", 8'h00, 4'd0, 0, 0);
`endif

    // Stop at idx=5 and start pulsed at idx=3
    applyStimulus(1, 0);
    while (m_k < 5 * BEAT + 3) begin
      applyStimulus(m_k == 3 * BEAT + 1, 0);
      checkModel("ignore_start");
    end
    checkOutput("at_idx5", 8'h20, 4'd5, 1, 0);
    applyStimulus(0, 1);
    checkOutput("stop_idx5", 8'h00, 4'd0, 0, 0);

    // Asynchronous reset mid-note
    applyStimulus(1, 0);
    repeat (3) applyStimulus(0, 0);
    checkOutput("pre_reset", 8'h01, 4'd0, 1, 0);
    #2 rst = 1'b1;
    #1 checkOutput("async_reset", 8'h00, 4'd0, 0, 0);
    m_play = 1'b0;
    m_done = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("reset_hold", 8'h00, 4'd0, 0, 0);
    rst = 1'b0;
    repeat (3) begin
      applyStimulus(0, 0);
      checkOutput("idle_after_release", 8'h00, 4'd0, 0, 0);
    end

    // Randomized start/stop traffic against the model
    for (int c = 0; c < 4000; c++) begin
      applyStimulus($urandom_range(0, 7) == 0, $urandom_range(0, 299) == 0);
      checkModel("random");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/melody_sequencer.md
# melody_sequencer

Plays a fixed 16-entry melody by driving the one-hot 8-note select bus of the piezo tone generator, one note at a time, with programmable beat length and an inter-note silence gap. Sits between the button/control logic and the tone generator. The tone generator interprets an all-zero select as silence, so this block owns note timing, rests and articulation.

## Interface
- BEAT_CYCLES, 250000: clock cycles per beat. Legal range 2..2^24.
- GAP_CYCLES, 10000: silent cycles at the end of every entry. Must satisfy 1 ≤ GAP_CYCLES < BEAT_CYCLES.
- clk  input  1  system clock; all logic is rising-edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  level; sampled only in IDLE.
- stop  input  1  level; aborts playback from any state.
- note_sel  output  8  one-hot note select to the tone generator. Bit0=C4 … bit7=C5; 0 means silence.
- busy  output  1  high while not in IDLE.
- done  output  1  one-cycle pulse when a non-looping song completes.
- idx  output  4  index of the current ROM entry.

## Operation
- Internal ROM, 16 entries. Each entry is a 4-bit note code plus a 2-bit duration.
  - Note code: 0 = rest; 1..8 map to note_sel = 1 << (code-1).
  - Duration d: the entry lasts (d+1) beats.
- ROM contents, idx 0..15: C,C,G,G,A,A,G(d=1),F,F,E,E,D,D,C(d=1),rest,rest. All other entries have d=0.
- FSM states:
  - IDLE: note_sel=0, busy=0. start=1 and stop=0 → NOTE, idx=0, counter loaded.
  - NOTE: note_sel = decoded entry (0 for rest). Lasts (d+1)·BEAT_CYCLES − GAP_CYCLES cycles, then → GAP.
  - GAP: note_sel=0 for GAP_CYCLES cycles. Then:
    - if idx<15: idx+1 → NOTE.
    - if idx=15: end-of-song handling (see Configuration).
- stop=1 in any state → IDLE on the next edge. note_sel=0, idx=0, no done pulse. stop has priority over start.
- start while busy is ignored; playback is not restarted.
- Down-counter width is ceil(log2(4·BEAT_CYCLES)). No wrap is possible within legal parameters.
- Reset values: state=IDLE, note_sel=0, busy=0, done=0, idx=0, counter=0.
- Reset mid-song returns immediately (asynchronously) to the reset values.

## Timing
- All outputs are registered.
- start sampled high in IDLE at edge T0 → note_sel, busy and idx are valid from T0 onward (first cycle after T0).
- Each entry occupies exactly (d+1)·BEAT_CYCLES cycles:
  - NOTE, then GAP.
  - idx increments on the same edge that begins the next NOTE.
- Whole song = 18 beats = 18·BEAT_CYCLES cycles from T0.
- Non-looping end: done=1 for the single cycle following the final GAP cycle. busy=0 in that same cycle.
- A start held high through done is accepted on the next IDLE cycle. Back-to-back playback therefore costs one idle cycle.
- A rest entry still contributes its GAP; note_sel stays 0 throughout it.

## Configuration
- MELODY_LOOP_EN
  - Defined: after idx=15 GAP, go to NOTE with idx=0 and no idle cycle. done never pulses. Playback continues until stop or rst.
  - Undefined: after idx=15 GAP, go to IDLE and pulse done.

## Test plan
Parameters BEAT_CYCLES=10, GAP_CYCLES=2 unless noted.
- Reset: assert rst mid-NOTE → note_sel=0, busy=0, idx=0, done=0 immediately. Hold 3 cycles, release; block stays in IDLE.
- Single entry: pulse start → note_sel=8'h01 for 8 cycles, then 8'h00 for 2 cycles; then note_sel=8'h01 with idx=1.
- Full song, loop disabled: 180 cycles after T0, done pulses once and busy falls. Check note_sel sequence 01,01,10,10,20,20,10(18 cycles),08,08,04,04,02,02,01(18 cycles),00,00.
- Stop: raise stop while idx=5 → next cycle note_sel=0, busy=0, idx=0, no done. Assert start and stop together in IDLE → remains IDLE.
- Start ignored while busy: pulse start at idx=3 → idx sequence and timing unchanged.
- MELODY_LOOP_EN defined: after idx=15 GAP, note_sel=8'h01 and idx=0 on the very next cycle. done stays 0 over 400 cycles.
